// File: rtl/spike_rate_decoder_if.sv
// Result bus of the spike rate decoder: per-channel counts, winner and tie,
// delivered with a valid/ready handshake.
interface spike_rate_decoder_if #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 6,
    parameter int IDX_W = 1
);
    logic                    out_valid;
    logic                    out_ready;
    logic [N_CH*CNT_W-1:0]   count_flat;
    logic [IDX_W-1:0]        winner;
    logic                    tie;

    modport master (output out_valid, count_flat, winner, tie, input out_ready);
    modport slave  (input out_valid, count_flat, winner, tie, output out_ready);
endinterface

// File: rtl/spike_rate_decoder.sv
// Counts spikes per channel over a fixed window and reports counts plus the winning channel.
// Optional first-spike sample index output is enabled by defining SPIKE_DECODE_FIRST_SPIKE_EN.
module spike_rate_decoder #(
    parameter int N_CH   = 2,
    parameter int WINDOW = 40,
    parameter int CNT_W  = 6,
    parameter int IDX_W  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH-1:0]      spike_in,
    input  logic                 start,
    output logic                 busy,
    spike_rate_decoder_if.master res
`ifdef SPIKE_DECODE_FIRST_SPIKE_EN
    ,
    output logic [N_CH*$clog2(WINDOW+1)-1:0] first_flat
`endif
);
    localparam int WC_W = $clog2(WINDOW + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

    state_t             state, next_state;
    logic [WC_W-1:0]    win_cnt;
    logic [CNT_W-1:0]   cnt      [N_CH];
    logic [CNT_W-1:0]   cnt_next [N_CH];
    logic [CNT_W-1:0]   best_cnt;
    logic [IDX_W-1:0]   best_idx;
    logic               best_tie;
    logic [IDX_W-1:0]   winner_q;
    logic               tie_q;
    logic               out_valid_q;
    logic               last_sample;
    logic [N_CH*CNT_W-1:0] count_flat_w;

    assign last_sample = (state == COUNT) && (win_cnt == WC_W'(WINDOW - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start)         next_state = COUNT;
            COUNT:   if (last_sample)   next_state = HOLD;
            HOLD:    if (res.out_ready) next_state = IDLE;
            default:                    next_state = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_next[i] = (cnt[i] == CNT_MAX) ? cnt[i] : cnt[i] + CNT_W'(spike_in[i]);
        end
    end

    // Strict greater-than keeps the lowest index on equal counts.
    always_comb begin
        best_cnt = cnt_next[0];
        best_idx = '0;
        best_tie = 1'b0;
        for (int i = 1; i < N_CH; i++) begin
            if (cnt_next[i] > best_cnt) begin
                best_cnt = cnt_next[i];
                best_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            if ((IDX_W'(i) != best_idx) && (cnt_next[i] == best_cnt)) best_tie = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt     <= '0;
            winner_q    <= '0;
            tie_q       <= 1'b0;
            busy        <= 1'b0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
        end else begin
            busy        <= (next_state != IDLE);
            out_valid_q <= (next_state == HOLD);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        win_cnt <= '0;
                        for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
                    end
                end
                COUNT: begin
                    win_cnt <= win_cnt + WC_W'(1);
                    for (int i = 0; i < N_CH; i++) cnt[i] <= cnt_next[i];
                    if (last_sample) begin
                        winner_q <= best_idx;
                        tie_q    <= best_tie;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        count_flat_w = '0;
        for (int i = 0; i < N_CH; i++) count_flat_w[i*CNT_W +: CNT_W] = cnt[i];
    end

    assign res.count_flat = count_flat_w;
    assign res.winner     = winner_q;
    assign res.tie        = tie_q;
    assign res.out_valid  = out_valid_q;

`ifdef SPIKE_DECODE_FIRST_SPIKE_EN
    logic [WC_W-1:0]      first_q [N_CH];
    logic [N_CH*WC_W-1:0] first_flat_w;

    // The 1-based sample index is the window counter value after this sample.
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && start)) begin
            for (int i = 0; i < N_CH; i++) first_q[i] <= '0;
        end else if (state == COUNT) begin
            for (int i = 0; i < N_CH; i++) begin
                if (spike_in[i] && (first_q[i] == '0)) first_q[i] <= win_cnt + WC_W'(1);
            end
        end
    end

    always_comb begin
        first_flat_w = '0;
        for (int i = 0; i < N_CH; i++) first_flat_w[i*WC_W +: WC_W] = first_q[i];
    end

    assign first_flat = first_flat_w;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: a CNT_W=6 instance plus a CNT_W=4 instance for saturation.
// Checks first_flat as well when SPIKE_DECODE_FIRST_SPIKE_EN is defined.
module tb_spike_rate_decoder;
    localparam int N_CH   = 2;
    localparam int WINDOW = 40;
    localparam int CNT_W  = 6;
    localparam int SAT_W  = 4;
    localparam int IDX_W  = 1;
    localparam int FW     = $clog2(WINDOW + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            out_ready;
    logic [N_CH-1:0] spike_in;
    logic            busy;
    logic            sat_busy;
    int              checks = 0;
    int              passed = 0;

    spike_rate_decoder_if #(.N_CH(N_CH), .CNT_W(CNT_W), .IDX_W(IDX_W)) bus ();
    spike_rate_decoder_if #(.N_CH(N_CH), .CNT_W(SAT_W), .IDX_W(IDX_W)) sat_bus ();

    assign bus.out_ready     = out_ready;
    assign sat_bus.out_ready = out_ready;

`ifdef SPIKE_DECODE_FIRST_SPIKE_EN
    logic [N_CH*FW-1:0] first_flat;
    logic [N_CH*FW-1:0] sat_first_flat;
`endif

    spike_rate_decoder #(.N_CH(N_CH), .WINDOW(WINDOW), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .spike_in(spike_in), .start(start), .busy(busy), .res(bus)
`ifdef SPIKE_DECODE_FIRST_SPIKE_EN
        , .first_flat(first_flat)
`endif
    );

    spike_rate_decoder #(.N_CH(N_CH), .WINDOW(WINDOW), .CNT_W(SAT_W), .IDX_W(IDX_W)) sat_dut (
        .clk(clk), .rst(rst), .spike_in(spike_in), .start(start), .busy(sat_busy), .res(sat_bus)
`ifdef SPIKE_DECODE_FIRST_SPIKE_EN
        , .first_flat(sat_first_flat)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("[TB] %s check did not hold", tag);
        end
    endtask

    task automatic checkOutput(input string tag, input int c0, input int c1, input int w, input int t);
        check_value({tag, ".count0"}, 64'(bus.count_flat[0 +: CNT_W]), 64'(c0));
        check_value({tag, ".count1"}, 64'(bus.count_flat[CNT_W +: CNT_W]), 64'(c1));
        check_value({tag, ".winner"}, 64'(bus.winner), 64'(w));
        check_value({tag, ".tie"}, 64'(bus.tie), 64'(t));
    endtask

    task automatic check_sat(input string tag, input int c0, input int c1, input int w, input int t);
        check_value({tag, ".sat_count0"}, 64'(sat_bus.count_flat[0 +: SAT_W]), 64'(c0));
        check_value({tag, ".sat_count1"}, 64'(sat_bus.count_flat[SAT_W +: SAT_W]), 64'(c1));
        check_value({tag, ".sat_winner"}, 64'(sat_bus.winner), 64'(w));
        check_value({tag, ".sat_tie"}, 64'(sat_bus.tie), 64'(t));
    endtask

    task automatic check_first(input string tag, input int f0, input int f1);
`ifdef SPIKE_DECODE_FIRST_SPIKE_EN
        check_value({tag, ".first0"}, 64'(first_flat[0 +: FW]), 64'(f0));
        check_value({tag, ".first1"}, 64'(first_flat[FW +: FW]), 64'(f1));
`else
        if (f0 < 0 || f1 < 0) $display("[TB] %s: negative first-spike index requested", tag);
`endif
    endtask

    // Bit k-1 of each mask is the spike for sample k; start_mid pulses start inside COUNT.
    task automatic applyStimulus(input logic [WINDOW-1:0] m0, input logic [WINDOW-1:0] m1,
                                 input bit start_mid);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_value("busy_after_start", 64'(busy), 64'd1);
        for (int k = 1; k <= WINDOW; k++) begin
            spike_in = {m1[k-1], m0[k-1]};
            start    = start_mid && (k == 10 || k == 25);
            tick();
            if (k == WINDOW - 1) check_value("valid_before_last", 64'(bus.out_valid), 64'd0);
        end
        start    = 1'b0;
        spike_in = '0;
        check_value("valid_latency", 64'(bus.out_valid), 64'd1);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        spike_in  = '0;
        tick();
        tick();
        rst = 1'b0;
        $display("[TB] reset state");
        check_value("rst_busy", 64'(busy), 64'd0);
        check_value("rst_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst", 0, 0, 0, 0);

        $display("[TB] rate readout with backpressure");
        applyStimulus(40'h55_5555_5555, 40'h88_8888_8888, 1'b0);
        checkOutput("rate", 20, 10, 0, 0);
        check_sat("rate", 15, 10, 0, 0);
        check_first("rate", 1, 4);
        for (int c = 0; c < 10; c++) begin
            start = (c == 3);
            tick();
            check_value("hold_valid", 64'(bus.out_valid), 64'd1);
            check_value("hold_busy", 64'(busy), 64'd1);
        end
        start = 1'b0;
        checkOutput("hold", 20, 10, 0, 0);
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check_value("xfer_valid", 64'(bus.out_valid), 64'd0);
        check_value("xfer_busy", 64'(busy), 64'd0);
        checkOutput("idle_keep", 20, 10, 0, 0);

        $display("[TB] tie with start inside COUNT");
        applyStimulus(40'h00_0000_001F, 40'h00_01F0_0000, 1'b1);
        checkOutput("tie", 5, 5, 0, 1);
        check_first("tie", 1, 21);
        out_ready = 1'b1;
        tick();
        check_value("tie_xfer_valid", 64'(bus.out_valid), 64'd0);

        $display("[TB] all-zero with ready held high");
        applyStimulus('0, '0, 1'b0);
        checkOutput("zero", 0, 0, 0, 1);
        check_first("zero", 0, 0);
        tick();
        check_value("zero_xfer_valid", 64'(bus.out_valid), 64'd0);
        out_ready = 1'b0;

        $display("[TB] saturation");
        applyStimulus(40'h00_0010_0404, 40'hFF_FFFF_FFFF, 1'b0);
        checkOutput("sat_main", 3, 40, 1, 0);
        check_sat("sat", 3, 15, 1, 0);
        check_first("sat", 3, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        $display("[TB] reset during COUNT");
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            spike_in = {1'b1, 1'b1};
            rst      = (k == 17);
            tick();
        end
        rst      = 1'b0;
        spike_in = '0;
        check_value("rstc_busy", 64'(busy), 64'd0);
        check_value("rstc_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rstc", 0, 0, 0, 0);
        tick();
        check_value("rstc_stays_idle", 64'(busy), 64'd0);

        $display("[TB] reset during HOLD");
        applyStimulus(40'h00_0000_001F, 40'h00_01F0_0000, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_value("rsth_busy", 64'(busy), 64'd0);
        check_value("rsth_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rsth", 0, 0, 0, 0);
        check_first("rsth", 0, 0);

        $display("[TB] fresh window after reset");
        applyStimulus(40'h00_0000_0024, '0, 1'b0);
        checkOutput("fresh", 2, 0, 0, 0);
        check_first("fresh", 3, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_value("fresh_xfer_valid", 64'(bus.out_valid), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
